// File: rtl/score_keeper_if.sv
// Scoring bus between the judgement/video timing logic and the score keeper.
// The master drives the game and judgement pulses; the slave returns score state.
interface score_keeper_if;
  logic        game_start;
  logic        game_end;
  logic        hit;
  logic        miss;
  logic        frame_start;
  logic [16:0] score;
  logic [5:0]  digit_color;
  logic [16:0] score_live;
  logic [9:0]  streak;
  logic [2:0]  multiplier;
  logic        playing;

  modport master (
    output game_start, game_end, hit, miss, frame_start,
    input  score, digit_color, score_live, streak, multiplier, playing
  );

  modport slave (
    input  game_start, game_end, hit, miss, frame_start,
    output score, digit_color, score_live, streak, multiplier, playing
  );
endinterface

// File: rtl/score_keeper.sv
// Running score, streak and combo multiplier for the HUD, with a copy of the
// score and digit colour latched once per video frame for the renderer.
module score_keeper #(
  parameter int unsigned HIT_POINTS  = 10,
  parameter int unsigned STREAK_STEP = 10,
  parameter int unsigned MAX_MULT    = 4,
  parameter int unsigned SCORE_MAX   = 99999
) (
  input  logic          clk,
  input  logic          reset,
  score_keeper_if.slave bus
);
  localparam int unsigned STEP_W = (STREAK_STEP > 1) ? $clog2(STREAK_STEP) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t            state_reg;
  logic [16:0]       score_reg;
  logic [5:0]        color_reg;
  logic [16:0]       live_reg;
  logic [9:0]        streak_reg;
  logic [2:0]        mult_reg;
  logic              playing_reg;
  logic [STEP_W-1:0] step_reg;

  logic [19:0]       sum_next;
  logic [16:0]       live_next;
  logic [5:0]        color_next;

  // Sum is widened to 20 bits so saturation sees the true total, never a wrapped one.
  always_comb begin
    sum_next  = 20'(live_reg) + 20'(HIT_POINTS) * 20'(mult_reg);
    live_next = (sum_next > 20'(SCORE_MAX)) ? 17'(SCORE_MAX) : sum_next[16:0];
    case (mult_reg)
      3'd1:    color_next = 6'b111111;
      3'd2:    color_next = 6'b001100;
      3'd3:    color_next = 6'b111000;
      default: color_next = 6'b110011;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      score_reg   <= '0;
      color_reg   <= 6'b111111;
      live_reg    <= '0;
      streak_reg  <= '0;
      mult_reg    <= 3'd1;
      playing_reg <= 1'b0;
      step_reg    <= '0;
    end else begin
      // Display copy samples pre-update values; game_start below overrides it.
      if (bus.frame_start) begin
        score_reg <= live_reg;
        color_reg <= color_next;
      end
      if (bus.game_start) begin
        state_reg   <= PLAY;
        playing_reg <= 1'b1;
        score_reg   <= '0;
        color_reg   <= 6'b111111;
        live_reg    <= '0;
        streak_reg  <= '0;
        mult_reg    <= 3'd1;
        step_reg    <= '0;
      end else if (state_reg == PLAY) begin
        if (bus.game_end) begin
          state_reg   <= DONE;
          playing_reg <= 1'b0;
        end else if (bus.miss) begin
          streak_reg <= '0;
          mult_reg   <= 3'd1;
          step_reg   <= '0;
        end else if (bus.hit) begin
          live_reg <= live_next;
          if (streak_reg < 10'd999)
            streak_reg <= streak_reg + 10'd1;
          if (step_reg == STEP_W'(STREAK_STEP - 1)) begin
            step_reg <= '0;
            if (mult_reg < 3'(MAX_MULT))
              mult_reg <= mult_reg + 3'd1;
          end else begin
            step_reg <= step_reg + 1'b1;
          end
        end
      end
    end
  end

  assign bus.score       = score_reg;
  assign bus.digit_color = color_reg;
  assign bus.score_live  = live_reg;
  assign bus.streak      = streak_reg;
  assign bus.multiplier  = mult_reg;
  assign bus.playing     = playing_reg;
endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a behavioural model queues the expected
// output snapshot per driven cycle, and each test drains and compares it.
module tb_score_keeper;
  typedef struct packed {
    logic [16:0] score;
    logic [5:0]  color;
    logic [16:0] live;
    logic [9:0]  streak;
    logic [2:0]  mult;
    logic        playing;
  } snap_t;

  localparam snap_t RESET_SNAP = '{score: 17'd0, color: 6'b111111, live: 17'd0,
                                   streak: 10'd0, mult: 3'd1, playing: 1'b0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;

  snap_t exp_q[$];
  snap_t obs_q[$];

  // Behavioural model state
  int m_state = 0;  // 0 idle, 1 play, 2 done
  int m_live = 0, m_streak = 0, m_step = 0, m_mult = 1, m_score = 0;
  logic [5:0] m_color = 6'b111111;

  score_keeper_if sk_if ();

  score_keeper dut (
    .clk  (clk),
    .reset(reset),
    .bus  (sk_if)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] color_of(int mult);
    if (mult == 1) return 6'b111111;
    if (mult == 2) return 6'b001100;
    if (mult == 3) return 6'b111000;
    return 6'b110011;
  endfunction

  function automatic snap_t observe();
    return {sk_if.score, sk_if.digit_color, sk_if.score_live, sk_if.streak,
            sk_if.multiplier, sk_if.playing};
  endfunction

  function automatic snap_t model_snap();
    return {17'(m_score), m_color, 17'(m_live), 10'(m_streak), 3'(m_mult),
            (m_state == 1)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_live = 0; m_streak = 0; m_step = 0; m_mult = 1;
    m_score = 0; m_color = 6'b111111;
  endtask

  // Drive one cycle of pulses, push the model's prediction, capture the DUT.
  task automatic drive(input bit gs, input bit ge, input bit h, input bit m, input bit fs);
    @(negedge clk);
    sk_if.game_start = gs; sk_if.game_end = ge; sk_if.hit = h;
    sk_if.miss = m; sk_if.frame_start = fs;
    if (fs) begin
      m_score = m_live;
      m_color = color_of(m_mult);
    end
    if (gs) begin
      m_state = 1; m_live = 0; m_streak = 0; m_step = 0; m_mult = 1;
      m_score = 0; m_color = 6'b111111;
    end else if (m_state == 1) begin
      if (ge) m_state = 2;
      else if (m) begin
        m_streak = 0; m_step = 0; m_mult = 1;
      end else if (h) begin
        m_live = m_live + 10 * m_mult;
        if (m_live > 99999) m_live = 99999;
        if (m_streak < 999) m_streak++;
        m_step++;
        if (m_step == 10) begin
          m_step = 0;
          if (m_mult < 4) m_mult++;
        end
      end
    end
    exp_q.push_back(model_snap());
    @(posedge clk);
    #1;
    obs_q.push_back(observe());
    sk_if.game_start = 0; sk_if.game_end = 0; sk_if.hit = 0;
    sk_if.miss = 0; sk_if.frame_start = 0;
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1, 0, 0);
  endtask

  task automatic test_reset();
    snap_t o;
    sk_if.game_start = 0; sk_if.game_end = 0; sk_if.hit = 0;
    sk_if.miss = 0; sk_if.frame_start = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    o = observe();
    n_cmp++;
    if (o !== RESET_SNAP) begin
      n_bad++;
      $display("FAIL reset_values got %h required %h", o, RESET_SNAP);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    $display("test_reset: snapshot %h", o);
  endtask

  task automatic test_hits();
    snap_t e, o;
    drive(1, 0, 0, 0, 0);
    hits(10);
    n_cmp++;
    if (sk_if.score_live !== 17'd100 || sk_if.streak !== 10'd10 || sk_if.multiplier !== 3'd2) begin
      n_bad++;
      $display("FAIL ten_hits got live=%0d streak=%0d mult=%0d required 100/10/2",
               sk_if.score_live, sk_if.streak, sk_if.multiplier);
    end
    hits(1);
    n_cmp++;
    if (sk_if.score_live !== 17'd120) begin
      n_bad++;
      $display("FAIL eleventh_hit got %0d required 120", sk_if.score_live);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL hits_sb got %h required %h", o, e); end
    end
    $display("test_hits: live=%0d", sk_if.score_live);
  endtask

  task automatic test_max_mult();
    snap_t e, o;
    drive(1, 0, 0, 0, 0);
    hits(41);
    n_cmp++;
    if (sk_if.score_live !== 17'd1040 || sk_if.multiplier !== 3'd4 || sk_if.streak !== 10'd41) begin
      n_bad++;
      $display("FAIL max_mult got live=%0d mult=%0d streak=%0d required 1040/4/41",
               sk_if.score_live, sk_if.multiplier, sk_if.streak);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL max_mult_sb got %h required %h", o, e); end
    end
    $display("test_max_mult: live=%0d mult=%0d", sk_if.score_live, sk_if.multiplier);
  endtask

  task automatic test_miss();
    snap_t e, o;
    drive(1, 0, 0, 0, 0);
    hits(25);
    drive(0, 0, 0, 1, 0);
    n_cmp++;
    if (sk_if.score_live !== 17'd450 || sk_if.streak !== 10'd0 || sk_if.multiplier !== 3'd1) begin
      n_bad++;
      $display("FAIL miss got live=%0d streak=%0d mult=%0d required 450/0/1",
               sk_if.score_live, sk_if.streak, sk_if.multiplier);
    end
    hits(1);
    n_cmp++;
    if (sk_if.score_live !== 17'd460) begin
      n_bad++;
      $display("FAIL after_miss got %0d required 460", sk_if.score_live);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL miss_sb got %h required %h", o, e); end
    end
    $display("test_miss: live=%0d", sk_if.score_live);
  endtask

  task automatic test_hit_miss_end();
    snap_t e, o;
    drive(1, 0, 0, 0, 0);
    hits(9);
    drive(0, 0, 1, 1, 0);
    n_cmp++;
    if (sk_if.score_live !== 17'd90 || sk_if.streak !== 10'd0) begin
      n_bad++;
      $display("FAIL hit_and_miss got live=%0d streak=%0d required 90/0",
               sk_if.score_live, sk_if.streak);
    end
    drive(0, 1, 0, 0, 0);
    hits(5);
    n_cmp++;
    if (sk_if.score_live !== 17'd90 || sk_if.playing !== 1'b0) begin
      n_bad++;
      $display("FAIL after_end got live=%0d playing=%b required 90/0",
               sk_if.score_live, sk_if.playing);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL end_sb got %h required %h", o, e); end
    end
    $display("test_hit_miss_end: live=%0d playing=%b", sk_if.score_live, sk_if.playing);
  endtask

  task automatic test_frame();
    snap_t e, o;
    drive(1, 0, 0, 0, 0);
    hits(9);
    drive(0, 0, 1, 0, 1);
    n_cmp++;
    if (sk_if.score !== 17'd90 || sk_if.digit_color !== 6'b111111) begin
      n_bad++;
      $display("FAIL frame_same_cycle got score=%0d color=%b required 90/111111",
               sk_if.score, sk_if.digit_color);
    end
    drive(0, 0, 0, 0, 1);
    n_cmp++;
    if (sk_if.score !== 17'd100 || sk_if.digit_color !== 6'b001100) begin
      n_bad++;
      $display("FAIL frame_next got score=%0d color=%b required 100/001100",
               sk_if.score, sk_if.digit_color);
    end
    hits(3);
    n_cmp++;
    if (sk_if.score !== 17'd100) begin
      n_bad++;
      $display("FAIL frame_hold got %0d required 100", sk_if.score);
    end
    drive(1, 0, 0, 0, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL frame_sb got %h required %h", o, e); end
    end
    $display("test_frame: score=%0d color=%b", sk_if.score, sk_if.digit_color);
  endtask

  task automatic test_saturate_reset();
    snap_t e, o;
    drive(1, 0, 0, 0, 0);
    hits(2600);
    n_cmp++;
    if (sk_if.score_live !== 17'd99999 || sk_if.streak !== 10'd999) begin
      n_bad++;
      $display("FAIL saturate got live=%0d streak=%0d required 99999/999",
               sk_if.score_live, sk_if.streak);
    end
    drive(0, 0, 0, 0, 1);
    hits(10);
    // Async reset lands mid-cycle; outputs must clear before the next edge.
    @(negedge clk);
    sk_if.hit = 1'b1;
    #2 reset = 1'b1;
    #1;
    o = observe();
    n_cmp++;
    if (o !== RESET_SNAP) begin
      n_bad++;
      $display("FAIL async_reset got %h required %h", o, RESET_SNAP);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    sk_if.hit = 1'b0;
    hits(5);
    drive(1, 0, 0, 0, 0);
    hits(1);
    n_cmp++;
    if (sk_if.score_live !== 17'd10 || sk_if.playing !== 1'b1) begin
      n_bad++;
      $display("FAIL restart got live=%0d playing=%b required 10/1",
               sk_if.score_live, sk_if.playing);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL saturate_sb got %h required %h", o, e); end
    end
    $display("test_saturate_reset: live=%0d", sk_if.score_live);
  endtask

  initial begin
    test_reset();
    test_hits();
    test_max_mult();
    test_miss();
    test_hit_miss_end();
    test_frame();
    test_saturate_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
